volume_ramp: RTL and testbench

VOLUME_RAMP -- requirements
Module: volume_ramp

---
 rtl/volume_ramp_if.sv | 26 ++
 rtl/volume_ramp.sv | 135 +++++++++++++
 tb/tb_volume_ramp.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/volume_ramp_if.sv
// Stream bundle for volume_ramp: sample input, scaled output and the clip flag that
// travels with each output beat.
interface volume_ramp_if #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 1
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic [CH_W-1:0]          s_chan;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_data;
  logic [CH_W-1:0]          m_chan;
  logic                     clip;

  modport slave (
    input  s_valid, s_data, s_chan, m_ready,
    output s_ready, m_valid, m_data, m_chan, clip
  );

  modport master (
    output s_valid, s_data, s_chan, m_ready,
    input  s_ready, m_valid, m_data, m_chan, clip
  );
endinterface

// File: rtl/volume_ramp.sv
// Per-frame gain ramp with a 2-stage elastic multiply/saturate pipeline. Gain steps only on
// accepted frame-end beats, so every channel of a frame sees the same gain.
module volume_ramp #(
  parameter int DATA_W     = 16,
  parameter int CHANNELS   = 2,
  parameter int GAIN_W     = 9,
  parameter int RAMP_STEP  = 1,
  parameter int RESET_GAIN = 0,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  volume_ramp_if.slave      bus,
  input  logic [GAIN_W-1:0] gain_target,
  input  logic              gain_load,
  input  logic              mute,
  output logic [GAIN_W-1:0] gain_current,
  output logic              ramping
);
  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(1) << (GAIN_W - 1);
  localparam int                STEP_MAX = (1 << GAIN_W) - 1;
  localparam logic [GAIN_W-1:0] STEP     = GAIN_W'((RAMP_STEP > STEP_MAX) ? STEP_MAX : RAMP_STEP);
  localparam int                PROD_W   = DATA_W + GAIN_W + 1;
  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'(DATA_MAX);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = PROD_W'(DATA_MIN);

  // gain control state
  logic [GAIN_W-1:0] r_gain, r_target;
  logic              r_mute;
  state_t            r_state;
  logic [GAIN_W-1:0] w_gain_next, w_eff_target, w_up, w_dn;
  state_t            w_state_next;

  // pipeline state
  logic                     r_a_valid, r_b_valid, r_b_clip;
  logic signed [DATA_W-1:0] r_a_data, r_b_data;
  logic [GAIN_W-1:0]        r_a_gain;
  logic [CH_W-1:0]          r_a_chan, r_b_chan;
  logic                     w_a_adv, w_b_adv, w_accept, w_frame_end;
  logic signed [PROD_W-1:0] w_a_ext, w_g_ext, w_prod, w_shift;
  logic                     w_sat_hi, w_sat_lo;
  logic signed [DATA_W-1:0] w_sat_data;

  // Mute is registered so a change coincident with a frame end only affects the next one.
  assign w_eff_target = r_mute ? '0 : r_target;
  assign w_up         = w_eff_target - r_gain;
  assign w_dn         = r_gain - w_eff_target;

  assign w_b_adv     = !r_b_valid || bus.m_ready;
  assign w_a_adv     = !r_a_valid || w_b_adv;
  assign bus.s_ready = !rst && w_a_adv;
  assign w_accept    = bus.s_valid && bus.s_ready;
  assign w_frame_end = w_accept && (bus.s_chan == CH_W'(CHANNELS - 1));

  always_comb begin
    w_gain_next = r_gain;
    if (w_frame_end) begin
      if (r_gain < w_eff_target)
        w_gain_next = (w_up > STEP) ? r_gain + STEP : w_eff_target;
      else if (r_gain > w_eff_target)
        w_gain_next = (w_dn > STEP) ? r_gain - STEP : w_eff_target;
    end
  end

  always_comb begin
    w_state_next = RAMP;
    if (r_gain == w_eff_target)
      w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gain   <= GAIN_W'(RESET_GAIN);
      r_target <= UNITY;
      r_mute   <= 1'b0;
      r_state  <= (GAIN_W'(RESET_GAIN) != UNITY) ? RAMP : IDLE;
    end else begin
      r_gain  <= w_gain_next;
      r_mute  <= mute;
      r_state <= w_state_next;
      if (gain_load)
        r_target <= gain_target;
    end
  end

  // Sample is signed, gain is unsigned: zero-extend the gain before the signed multiply.
  assign w_a_ext    = PROD_W'(r_a_data);
  assign w_g_ext    = PROD_W'({1'b0, r_a_gain});
  assign w_prod     = w_a_ext * w_g_ext;
  assign w_shift    = w_prod >>> (GAIN_W - 1);
  assign w_sat_hi   = w_shift > SAT_MAX;
  assign w_sat_lo   = w_shift < SAT_MIN;
  assign w_sat_data = w_sat_hi ? DATA_MAX : (w_sat_lo ? DATA_MIN : w_shift[DATA_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_data  <= '0;
      r_a_gain  <= '0;
      r_a_chan  <= '0;
      r_b_valid <= 1'b0;
      r_b_data  <= '0;
      r_b_chan  <= '0;
      r_b_clip  <= 1'b0;
    end else begin
      if (w_a_adv) begin
        r_a_valid <= w_accept;
        if (w_accept) begin
          r_a_data <= bus.s_data;
          r_a_gain <= r_gain;
          r_a_chan <= bus.s_chan;
        end
      end
      if (w_b_adv) begin
        r_b_valid <= r_a_valid;
        if (r_a_valid) begin
          r_b_data <= w_sat_data;
          r_b_chan <= r_a_chan;
          r_b_clip <= w_sat_hi || w_sat_lo;
        end
      end
    end
  end

  assign bus.m_valid  = r_b_valid;
  assign bus.m_data   = r_b_data;
  assign bus.m_chan   = r_b_chan;
  assign bus.clip     = r_b_valid && r_b_clip;
  assign gain_current = r_gain;
  assign ramping      = (r_state == RAMP);
endmodule

// File: tb/tb_volume_ramp.sv
// Randomised bench for volume_ramp: a frame-level gain model and an output queue predict
// every output beat, the gain after every cycle and the ramping flag.
module tb_volume_ramp;
  localparam int DATA_W     = 16;
  localparam int CHANNELS   = 2;
  localparam int CH_W       = 1;
  localparam int GAIN_W     = 9;
  localparam int STEP       = 16;
  localparam int RESET_GAIN = 0;
  localparam int UNITY      = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [GAIN_W-1:0] gain_target;
  logic              gain_load;
  logic              mute;
  logic [GAIN_W-1:0] gain_current;
  logic              ramping;

  volume_ramp_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  volume_ramp #(
    .DATA_W(DATA_W), .CHANNELS(CHANNELS), .GAIN_W(GAIN_W),
    .RAMP_STEP(STEP), .RESET_GAIN(RESET_GAIN)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .gain_target(gain_target), .gain_load(gain_load), .mute(mute),
    .gain_current(gain_current), .ramping(ramping)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  int g_m, tgt_m, chan_nxt;
  bit mute_m, after_rst, prev_stall;
  int prev_data, prev_chan, prev_clip;
  int q_data[$], q_chan[$], q_clip[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 time unit before the rising edge,
  // check registered gain state at the next falling edge.
  task automatic tick(input bit v, input int data, input bit rdy, input bit ld, input int tg, input bit mu);
    logic signed [15:0] d16;
    int ds, y, eff;
    bit acc, sat, exp_ramp;
    d16 = data[15:0];
    ds  = d16;
    bus.s_valid = v;
    bus.s_data  = d16;
    bus.s_chan  = CH_W'(chan_nxt);
    bus.m_ready = rdy;
    gain_load   = ld;
    gain_target = GAIN_W'(tg);
    mute        = mu;
    #4;
    if (after_rst) begin
      chk("s_ready_after_rst", bus.s_ready, 1);
      after_rst = 0;
    end
    acc = v && bus.s_ready;
    if (prev_stall) begin
      chk("stall_valid", bus.m_valid, 1);
      chk("stall_data", int'(bus.m_data), prev_data);
      chk("stall_chan", bus.m_chan, prev_chan);
      chk("stall_clip", bus.clip, prev_clip);
    end
    if (bus.m_valid && rdy) begin
      $display("beat chan=%0d data=%0d clip=%0d", bus.m_chan, bus.m_data, bus.clip);
      chk("beat_expected", q_data.size() > 0, 1);
      if (q_data.size() > 0) begin
        chk("m_data", int'(bus.m_data), q_data.pop_front());
        chk("m_chan", bus.m_chan, q_chan.pop_front());
        chk("clip", bus.clip, q_clip.pop_front());
      end
    end
    prev_stall = bus.m_valid && !rdy;
    prev_data  = int'(bus.m_data);
    prev_chan  = bus.m_chan;
    prev_clip  = bus.clip;

    eff      = mute_m ? 0 : tgt_m;
    exp_ramp = (g_m != eff);
    if (acc) begin
      y   = (ds * g_m) >>> (GAIN_W - 1);
      sat = 0;
      if (y > 32767) begin y = 32767; sat = 1; end
      else if (y < -32768) begin y = -32768; sat = 1; end
      q_data.push_back(y);
      q_chan.push_back(chan_nxt);
      q_clip.push_back(sat);
      if (chan_nxt == CHANNELS - 1) begin
        if (g_m < eff) g_m = g_m + min_i(STEP, eff - g_m);
        else if (g_m > eff) g_m = g_m - min_i(STEP, g_m - eff);
      end
      chan_nxt = (chan_nxt + 1) % CHANNELS;
    end
    if (ld) tgt_m = tg;
    mute_m = mu;
    @(posedge clk);
    @(negedge clk);
    chk("gain_current", gain_current, g_m);
    chk("ramping", ramping, exp_ramp);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    gain_load   = 1'b0;
    mute        = 1'b0;
    #4;
    chk("s_ready_in_rst", bus.s_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", int'(bus.m_data), 0);
    chk("rst_m_chan", bus.m_chan, 0);
    chk("rst_clip", bus.clip, 0);
    chk("rst_gain", gain_current, RESET_GAIN);
    chk("rst_ramping", ramping, RESET_GAIN != UNITY);
    g_m = RESET_GAIN; tgt_m = UNITY; mute_m = 0; chan_nxt = 0;
    q_data.delete(); q_chan.delete(); q_clip.delete();
    prev_stall = 0;
    after_rst  = 1;
    rst        = 1'b0;
  endtask

  task automatic align_frame_end();
    for (int i = 0; i < CHANNELS && chan_nxt != CHANNELS - 1; i++)
      tick(1, $urandom, 1, 0, 0, 0);
  endtask

  initial begin
    bit mute_lvl;
    rst = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0; bus.s_chan = '0; bus.m_ready = 1'b0;
    gain_load = 1'b0; gain_target = '0; mute = 1'b0;
    @(negedge clk);
    do_reset();

    // soft start: 0 -> unity, then a sample of 1000 passes unchanged
    for (int i = 0; i < 40; i++) tick(1, $urandom, 1, 0, 0, 0);
    tick(1, 1000, 1, 0, 0, 0);
    tick(1, 1000, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 0, 0);

    // near-2x gain with saturation in both directions
    tick(0, 0, 1, 1, 511, 0);
    for (int i = 0; i < 40; i++) tick(1, $urandom, 1, 0, 0, 0);
    tick(1, 20000, 1, 0, 0, 0);
    tick(1, -20000, 1, 0, 0, 0);
    tick(1, 100, 1, 0, 0, 0);
    tick(1, -100, 1, 0, 0, 0);

    // mute ramp down and back up to unity
    tick(0, 0, 1, 1, 256, 0);
    for (int i = 0; i < 40; i++) tick(1, $urandom, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) tick(1, $urandom, 1, 0, 0, 1);
    for (int i = 0; i < 40; i++) tick(1, $urandom, 1, 0, 0, 0);

    // gain_load coincident with a frame end, ramping down and then ramping up
    tick(0, 0, 1, 1, 200, 0);
    for (int i = 0; i < 12; i++) tick(1, $urandom, 1, 0, 0, 0);
    tick(0, 0, 1, 1, 0, 0);
    align_frame_end();
    tick(1, $urandom, 1, 1, 128, 0);
    for (int i = 0; i < 4; i++) tick(1, $urandom, 1, 0, 0, 0);
    tick(0, 0, 1, 1, 511, 0);
    align_frame_end();
    tick(1, $urandom, 1, 1, 128, 0);
    for (int i = 0; i < 4; i++) tick(1, $urandom, 1, 0, 0, 0);

    // random backpressure, loads and mute toggles
    mute_lvl = 0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 99) == 0) mute_lvl = !mute_lvl;
      tick($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
           $urandom_range(0, 49) == 0, $urandom_range(0, 511), mute_lvl);
    end

    // reset with both stages full; nothing stale may emerge afterwards
    for (int i = 0; i < 4; i++) tick(1, $urandom, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 40; i++) tick(1, $urandom, 1, 0, 0, 0);

    for (int i = 0; i < 6; i++) tick(0, 0, 1, 0, 0, 0);
    chk("drain_empty", q_data.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
